// File: rtl/la_txd_pkg.sv
// la_txd_pkg: shared types and constants for the analyzer-to-UART word
// serializer.
//   state_e            - serializer FSM state (IDLE, REQ, WAIT, DONE)
//   LA_BYTE_W          - UART byte width
//   LA_WORD_W_DEFAULT  - default analyzer word width
package la_txd_pkg;

  localparam int LA_BYTE_W         = 8;
  localparam int LA_WORD_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/la_txd_serializer_rise_detect.sv
// rise_detect: single-bit registered rising-edge detector.
//   clk  in  - clock, rising edge
//   rst  in  - synchronous active-high reset; the previous level loads RST_VAL
//   d    in  - level to watch
//   rise out - d is high now and was low in the previous cycle
// With RST_VAL = 1 a level that is already high coming out of reset is not
// reported as an edge; it must fall and rise again.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = d;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= RST_VAL;
    else     prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/la_txd_serializer.sv
// la_txd_serializer: splits one analyzer word into WORD_W/8 byte requests to
// the UART, waiting for the UART completion edge between bytes.
// Optional watchdog: define LA_TXD_WATCHDOG_EN to abort a byte that gets no
// completion edge within WDT_CYCLES cycles.
//
// Ports:
//   CLK, RST            - clock; synchronous active-high reset
//   TXD_ENABLE, TXD     - one-cycle word request and the word (sampled then)
//   TXD_DONE            - one-cycle pulse when the word finishes or aborts
//   BUSY                - high from the cycle after acceptance through TXD_DONE
//   OVERRUN             - sticky; a TXD_ENABLE arrived while REQ/WAIT
//   UART_TX_REQ         - one-cycle byte request
//   UART_TX_DATA        - byte, held from request until the completion edge
//   UART_TX_END         - UART completion level; only its rising edge counts
//   TIMEOUT             - one-cycle watchdog abort pulse (0 without watchdog)
//   DBG_STATE           - current FSM state for observation
//
// Handshake: the analyzer side is a fire-and-forget pulse; a word is accepted
// only in IDLE or DONE, anything else is dropped and flagged in OVERRUN. The
// UART side issues UART_TX_REQ for exactly one cycle and then treats the next
// rising edge of UART_TX_END as the byte's completion; the next request or
// TXD_DONE follows on the cycle after that edge.
module la_txd_serializer
  import la_txd_pkg::*;
#(
  parameter int WORD_W     = LA_WORD_W_DEFAULT,
  parameter bit LSB_FIRST  = 1'b1,
  parameter int WDT_CYCLES = 2**20
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TXD_ENABLE,
  input  logic [WORD_W-1:0]    TXD,
  output logic                 TXD_DONE,
  output logic                 BUSY,
  output logic                 OVERRUN,
  output logic                 UART_TX_REQ,
  output logic [LA_BYTE_W-1:0] UART_TX_DATA,
  input  logic                 UART_TX_END,
  output logic                 TIMEOUT,
  output state_e               DBG_STATE
);

  localparam int NB    = WORD_W / LA_BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  state_e                 state_q, state_d;
  logic [WORD_W-1:0]      word_q, word_d, word_shift;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LA_BYTE_W-1:0]   data_q, data_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   ovr_q, ovr_d;
  logic                   req_q, req_d;
  logic                   timeout_q, timeout_d;
  logic                   end_rise;
  logic                   wdt_expire;

  // The byte to send is always at the "front" of the shift register, so the
  // selection does not depend on the index.
  function automatic logic [LA_BYTE_W-1:0] first_byte(input logic [WORD_W-1:0] w);
    if (LSB_FIRST) return w[LA_BYTE_W-1:0];
    else           return w[WORD_W-1 -: LA_BYTE_W];
  endfunction

  rise_detect #(.RST_VAL(1'b1)) u_end_rise (
    .clk  (CLK),
    .rst  (RST),
    .d    (UART_TX_END),
    .rise (end_rise)
  );

`ifdef LA_TXD_WATCHDOG_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;

  assign wdt_expire = (state_q == ST_WAIT) && (wdt_q == WDT_LAST);

  // Counts only while staying in WAIT; any exit (completion, abort) or
  // entry to REQ leaves it at zero for the next byte.
  always_comb begin
    wdt_d = '0;
    if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) wdt_d = wdt_q + WDT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) wdt_q <= '0;
    else     wdt_q <= wdt_d;
  end
`else
  logic unused_wdt;
  assign unused_wdt = (WDT_CYCLES > 0);
  assign wdt_expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    data_d     = data_q;
    ovr_d      = ovr_q;
    timeout_d  = 1'b0;
    word_shift = LSB_FIRST ? (word_q >> LA_BYTE_W) : (word_q << LA_BYTE_W);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (TXD_ENABLE) begin
          state_d = ST_REQ;
          word_d  = TXD;
          idx_d   = '0;
          data_d  = first_byte(TXD);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (TXD_ENABLE) ovr_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (TXD_ENABLE) ovr_d = 1'b1;
        // A completion edge wins over a watchdog expiry in the same cycle.
        if (end_rise) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
            idx_d   = idx_q + IDX_W'(1);
            word_d  = word_shift;
            data_d  = first_byte(word_shift);
          end
        end else if (wdt_expire) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
    req_d  = (state_d == ST_REQ);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      req_q     <= req_d;
      timeout_q <= timeout_d;
    end
  end

  assign TXD_DONE     = done_q;
  assign BUSY         = busy_q;
  assign OVERRUN      = ovr_q;
  assign UART_TX_REQ  = req_q;
  assign UART_TX_DATA = data_q;
  assign TIMEOUT      = timeout_q;
  assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_la_txd_serializer.sv
// Bench for la_txd_serializer: two instances share all inputs, one sending
// least-significant byte first and one most-significant byte first, checked
// against byte queues built from the word.
module tb_la_txd_serializer;
  import la_txd_pkg::*;

  localparam int WORD_W = 16;
  localparam int NB     = WORD_W / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              txd_enable;
  logic [WORD_W-1:0] txd;
  logic              uart_tx_end;

  logic       done_l, busy_l, ovr_l, req_l, to_l;
  logic [7:0] data_l;
  state_e     st_l;
  logic       done_m, busy_m, ovr_m, req_m, to_m;
  logic [7:0] data_m;
  state_e     st_m;

  la_txd_serializer #(.WORD_W(WORD_W), .LSB_FIRST(1'b1), .WDT_CYCLES(64)) dut_lsb (
    .CLK(clk), .RST(rst), .TXD_ENABLE(txd_enable), .TXD(txd),
    .TXD_DONE(done_l), .BUSY(busy_l), .OVERRUN(ovr_l), .UART_TX_REQ(req_l),
    .UART_TX_DATA(data_l), .UART_TX_END(uart_tx_end), .TIMEOUT(to_l),
    .DBG_STATE(st_l)
  );

  la_txd_serializer #(.WORD_W(WORD_W), .LSB_FIRST(1'b0), .WDT_CYCLES(64)) dut_msb (
    .CLK(clk), .RST(rst), .TXD_ENABLE(txd_enable), .TXD(txd),
    .TXD_DONE(done_m), .BUSY(busy_m), .OVERRUN(ovr_m), .UART_TX_REQ(req_m),
    .UART_TX_DATA(data_m), .UART_TX_END(uart_tx_end), .TIMEOUT(to_m),
    .DBG_STATE(st_m)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         exp_ovr  = 1'b0;
  logic [7:0] exp_lq[$];
  logic [7:0] exp_mq[$];

  // Expected byte order for both instances, straight from the word.
  task automatic load_model(input logic [WORD_W-1:0] w);
    for (int i = 0; i < NB; i++) begin
      exp_lq.push_back(8'((w >> (8 * i)) & 16'h00FF));
      exp_mq.push_back(8'((w >> (8 * (NB - 1 - i))) & 16'h00FF));
    end
  endtask

  // ---------------- drivers ----------------
  // After tick() the outputs of the new cycle are visible and any input
  // driven now is sampled at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ovr = 1'b0;
    exp_lq.delete();
    exp_mq.delete();
  endtask

  // Sends one word starting in the current cycle, with an ideal UART that
  // raises its completion line 'gap' cycles after each request. Returns in
  // the TXD_DONE cycle, so a following call is a back-to-back word.
  task automatic run_word(input logic [WORD_W-1:0] w, input int gap, input bit poke);
    logic [7:0] lb, mb;
    bit quiet;
    txd = w;
    txd_enable = 1'b1;
    load_model(w);
    tick();
    txd_enable = 1'b0;
    for (int b = 0; b < NB; b++) begin
      lb = exp_lq.pop_front();
      mb = exp_mq.pop_front();
      n_checks++;
      if (req_l !== 1'b1 || data_l !== lb || done_l !== 1'b0) begin
        n_fail++;
        $display("FAIL req_lsb byte%0d: req=%b data=%h done=%b, required req=1 data=%h done=0",
                 b, req_l, data_l, done_l, lb);
      end
      n_checks++;
      if (req_m !== 1'b1 || data_m !== mb || done_m !== 1'b0) begin
        n_fail++;
        $display("FAIL req_msb byte%0d: req=%b data=%h done=%b, required req=1 data=%h done=0",
                 b, req_m, data_m, done_m, mb);
      end
      n_checks++;
      if (ovr_l !== exp_ovr || ovr_m !== exp_ovr) begin
        n_fail++;
        $display("FAIL overrun byte%0d: lsb=%b msb=%b, required %b", b, ovr_l, ovr_m, exp_ovr);
      end
      quiet = 1'b1;
      for (int g = 0; g < gap; g++) begin
        tick();
        if (poke && b == 0 && g == 0) begin
          txd        = 16'h1234;
          txd_enable = 1'b1;
          exp_ovr    = 1'b1;
        end else begin
          txd_enable = 1'b0;
        end
        if (req_l !== 1'b0 || req_m !== 1'b0 || done_l !== 1'b0 || done_m !== 1'b0 ||
            data_l !== lb || data_m !== mb || busy_l !== 1'b1 || busy_m !== 1'b1)
          quiet = 1'b0;
        if (g == gap - 1) uart_tx_end = 1'b1;
      end
      n_checks++;
      if (!quiet) begin
        n_fail++;
        $display("FAIL wait_quiet byte%0d: outputs moved while waiting, required req=0 done=0 busy=1 data=%h/%h",
                 b, lb, mb);
      end
      tick();
      uart_tx_end = 1'b0;
      txd_enable  = 1'b0;
    end
    n_checks++;
    if (done_l !== 1'b1 || done_m !== 1'b1 || busy_l !== 1'b1 || busy_m !== 1'b1 ||
        to_l !== 1'b0 || to_m !== 1'b0 || req_l !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b/%b busy=%b/%b timeout=%b/%b req=%b, required done=1 busy=1 timeout=0 req=0",
               done_l, done_m, busy_l, busy_m, to_l, to_m, req_l);
    end
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (done_l !== 1'b0 || done_m !== 1'b0 || busy_l !== 1'b0 || busy_m !== 1'b0 ||
        req_l !== 1'b0 || req_m !== 1'b0 || st_l !== ST_IDLE) begin
      n_fail++;
      $display("FAIL %s: done=%b/%b busy=%b/%b req=%b/%b state=%0d, required all 0 and IDLE",
               name, done_l, done_m, busy_l, busy_m, req_l, req_m, st_l);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({done_l, busy_l, ovr_l, req_l, to_l, data_l} !== 13'd0 ||
        {done_m, busy_m, ovr_m, req_m, to_m, data_m} !== 13'd0 ||
        st_l !== ST_IDLE || st_m !== ST_IDLE) begin
      n_fail++;
      $display("FAIL %s: lsb outs=%b_%b_%b_%b_%b data=%h, msb outs=%b_%b_%b_%b_%b data=%h, required all 0",
               name, done_l, busy_l, ovr_l, req_l, to_l, data_l,
               done_m, busy_m, ovr_m, req_m, to_m, data_m);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset_values");
    rst = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic test_basic();
    run_word(16'hA55A, 10, 1'b0);
    tick();
    check_idle("basic_after_done");
  endtask

  task automatic test_byte_order();
    run_word(16'hA55A, 3, 1'b0);
    tick();
    check_idle("order_after_done");
  endtask

  task automatic test_overrun_b2b();
    run_word(16'hA55A, 10, 1'b1);
    run_word(16'hBEEF, 4, 1'b0);
    tick();
    check_idle("b2b_after_done");
    n_checks++;
    if (ovr_l !== 1'b1 || ovr_m !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: lsb=%b msb=%b, required 1", ovr_l, ovr_m);
    end
  endtask

  task automatic test_held_high();
    bit quiet;
    uart_tx_end = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_ovr = 1'b0;
    txd = 16'hC33C;
    txd_enable = 1'b1;
    tick();
    txd_enable = 1'b0;
    n_checks++;
    if (req_l !== 1'b1 || data_l !== 8'h3C || data_m !== 8'hC3) begin
      n_fail++;
      $display("FAIL held_first_req: req=%b data=%h/%h, required req=1 data=3c/c3", req_l, data_l, data_m);
    end
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (req_l !== 1'b0 || done_l !== 1'b0 || busy_l !== 1'b1 || st_l !== ST_WAIT) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL held_no_edge: req=%b done=%b state=%0d, required byte not completed", req_l, done_l, st_l);
    end
    uart_tx_end = 1'b0;
    tick();
    uart_tx_end = 1'b1;
    tick();
    n_checks++;
    if (req_l !== 1'b1 || data_l !== 8'hC3 || data_m !== 8'h3C) begin
      n_fail++;
      $display("FAIL held_second_req: req=%b data=%h/%h, required req=1 data=c3/3c", req_l, data_l, data_m);
    end
    uart_tx_end = 1'b0;
    tick();
    uart_tx_end = 1'b1;
    tick();
    n_checks++;
    if (done_l !== 1'b1 || done_m !== 1'b1) begin
      n_fail++;
      $display("FAIL held_done: done=%b/%b, required 1", done_l, done_m);
    end
    uart_tx_end = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_word();
    bit saw_done;
    txd = 16'h5AA5;
    txd_enable = 1'b1;
    tick();
    txd_enable = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ovr = 1'b0;
    check_all_zero("reset_mid_word");
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      uart_tx_end = (i == 1);
      tick();
      if (done_l !== 1'b0 || done_m !== 1'b0) saw_done = 1'b1;
    end
    uart_tx_end = 1'b0;
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_no_done: done seen=1, required 0");
    end
    run_word(16'h0FF0, 2, 1'b0);
    tick();
    check_idle("after_reset_word");
  endtask

  task automatic test_random();
    logic [WORD_W-1:0] w;
    int gap;
    bit poke;
    bit b2b;
    for (int n = 0; n < 10; n++) begin
      w    = WORD_W'($urandom);
      gap  = $urandom_range(1, 12);
      poke = ($urandom_range(0, 3) == 0);
      b2b  = ($urandom_range(0, 1) == 1) && (n != 9);
      run_word(w, gap, poke);
      if (!b2b) begin
        tick();
        check_idle("random_idle");
        repeat ($urandom_range(0, 2)) tick();
      end
    end
  endtask

  task automatic test_watchdog();
    pulse_reset();
    uart_tx_end = 1'b0;
    txd = 16'h7E81;
    txd_enable = 1'b1;
    tick();
    txd_enable = 1'b0;
`ifdef LA_TXD_WATCHDOG_EN
    begin
      int cnt;
      cnt = 0;
      while (done_l !== 1'b1 && cnt < 200) begin
        tick();
        cnt++;
      end
      n_checks++;
      if (cnt != 65 || to_l !== 1'b1 || to_m !== 1'b1 || done_m !== 1'b1) begin
        n_fail++;
        $display("FAIL wdt_abort: cycles after req=%0d timeout=%b/%b done=%b/%b, required 65 and all 1",
                 cnt, to_l, to_m, done_l, done_m);
      end
      tick();
      check_idle("wdt_idle");
      n_checks++;
      if (to_l !== 1'b0 || to_m !== 1'b0) begin
        n_fail++;
        $display("FAIL wdt_pulse_width: timeout=%b/%b, required 0", to_l, to_m);
      end
    end
`else
    begin
      bit saw;
      saw = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        tick();
        if (to_l !== 1'b0 || to_m !== 1'b0 || done_l !== 1'b0 || done_m !== 1'b0) saw = 1'b1;
      end
      n_checks++;
      if (saw || busy_l !== 1'b1 || busy_m !== 1'b1 || st_l !== ST_WAIT) begin
        n_fail++;
        $display("FAIL no_wdt_hold: saw done/timeout=%b busy=%b/%b state=%0d, required busy=1 in WAIT",
                 saw, busy_l, busy_m, st_l);
      end
      pulse_reset();
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst         = 1'b1;
    txd_enable  = 1'b0;
    txd         = '0;
    uart_tx_end = 1'b0;
    test_reset();
    test_basic();
    test_byte_order();
    test_overrun_b2b();
    test_held_high();
    test_reset_mid_word();
    test_random();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/la_txd_serializer.md
# la_txd_serializer

Bridges the logic analyzer's 16-bit transmit word interface to the byte-wide UART transmitter. Accepts one word per `TXD_ENABLE` pulse and issues it as successive byte requests, waiting for the UART's completion edge between bytes. Returns a single-cycle `TXD_DONE` only after the last byte completes. Replaces the ad-hoc `tx_end` edge-detect flop and the truncation to `TXD[7:0]` at the analyzer/UART boundary.

## Interface
- `WORD_W`, 16: analyzer word width; must be a multiple of 8.
- `LSB_FIRST`, 1: 1 = byte 0 (`TXD[7:0]`) sent first; 0 = most-significant byte first.
- `WDT_CYCLES`, 2**20: watchdog limit in `CLK` cycles per byte. Used only with `LA_TXD_WATCHDOG_EN`.

Ports:
- `CLK` in 1: sole clock. All logic is on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `TXD_ENABLE` in 1: single-cycle word request from the analyzer.
- `TXD` in `WORD_W`: word to send; sampled only in the `TXD_ENABLE` cycle.
- `TXD_DONE` out 1: single-cycle pulse when the word is finished (or aborted by timeout).
- `BUSY` out 1: high from the cycle after acceptance through the `TXD_DONE` cycle.
- `OVERRUN` out 1: sticky; set by a `TXD_ENABLE` that is rejected. Cleared only by `RST`.
- `UART_TX_REQ` out 1: single-cycle byte request to the UART.
- `UART_TX_DATA` out 8: byte being sent; stable from `UART_TX_REQ` until the completion edge.
- `UART_TX_END` in 1: UART completion level. Only its rising edge counts.
- `TIMEOUT` out 1: single-cycle pulse on watchdog abort. Tied to 0 when the watchdog is compiled out.

## Operation
- **IDLE.**
  - `TXD_ENABLE` latches `TXD` into the shift register, sets byte index to 0, and moves to REQ.
- **REQ** (one cycle).
  - `UART_TX_REQ`=1 and `UART_TX_DATA` = the selected byte.
  - Moves to WAIT.
- **WAIT.**
  - A rising edge of `UART_TX_END` completes the current byte.
  - If more bytes remain: increment the index and go to REQ.
  - If this was the last byte: go to DONE.
- **DONE** (one cycle).
  - `TXD_DONE`=1, then return to IDLE.
  - A `TXD_ENABLE` in this cycle is accepted exactly as in IDLE and goes directly to REQ.
- **Edge detect.**
  - Previous-level register is updated every cycle and resets to 1, so a `UART_TX_END` that is already high after reset is not an edge.
  - An edge counts only in WAIT. Edges seen in IDLE, REQ or DONE are ignored.
- **Rejected requests.**
  - `TXD_ENABLE` in REQ or WAIT is ignored: the latched word is unchanged and `OVERRUN` is set.
- **Byte count.**
  - Number of bytes = `WORD_W`/8.
  - The index counter is `$clog2(WORD_W/8)` bits wide, minimum 1 bit.
- **Reset.**
  - All outputs reset to 0 (`TXD_DONE`, `BUSY`, `OVERRUN`, `UART_TX_REQ`, `UART_TX_DATA`, `TIMEOUT`). State goes to IDLE.
  - `RST` in the middle of a word aborts it with no `TXD_DONE`.

## Timing
- Latency from `TXD_ENABLE` at cycle 0 to `UART_TX_REQ` is 1 cycle (REQ at cycle 1).
- If the `UART_TX_END` edge is seen at cycle k:
  - the next byte's `UART_TX_REQ` is at k+1;
  - after the last byte, `TXD_DONE` is at k+1.
- Minimum word time, with an ideal UART whose edge arrives 1 cycle after request: 2·N+1 cycles for N bytes.
- Back-to-back throughput: a word accepted in a DONE cycle has its first `UART_TX_REQ` on the next cycle, so no idle bubble.
- `UART_TX_DATA` is registered and does not change in WAIT.

## Configuration
- `LA_TXD_WATCHDOG_EN` defined:
  - A counter runs in WAIT and clears on every byte completion and on entry to REQ.
  - When it reaches `WDT_CYCLES-1` without an edge: `TIMEOUT`=1 and `TXD_DONE`=1 in the same cycle, remaining bytes are dropped, and the block returns to IDLE. The analyzer therefore never hangs.
- `LA_TXD_WATCHDOG_EN` undefined:
  - No counter. WAIT lasts indefinitely. `TIMEOUT` is constant 0.

## Structure
- Package `la_txd_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, DONE);
  - `LA_BYTE_W`=8;
  - the default `WORD_W`.
- One sub-module, `rise_detect`: single-bit registered rising-edge detector with a reset value parameter. It is instantiated with reset value 1 for `UART_TX_END`.

## Test plan
- **Basic send.** `TXD`=16'hA55A, `LSB_FIRST`=1, UART model raises `UART_TX_END` 10 cycles after each request.
  - Expect bytes 8'h5A then 8'hA5.
  - Expect `TXD_DONE` exactly once, 1 cycle after the second edge.
- **Byte order.** Same word with `LSB_FIRST`=0 → bytes 8'hA5 then 8'h5A.
- **Overrun and back-to-back.**
  - `TXD_ENABLE` with 16'h1234 while in WAIT → word unchanged, `OVERRUN`=1 and stays set.
  - `TXD_ENABLE` with 16'hBEEF in the DONE cycle → `UART_TX_REQ` on the next cycle with 8'hEF.
- **Held-high `UART_TX_END`.** Line is high through reset and stays high → no byte is counted until a fall and a new rise.
- **Reset mid-word.** `RST` during WAIT of byte 0 → all outputs 0 on the next cycle, no `TXD_DONE`, and a subsequent word sends normally.
- **Watchdog.** With `LA_TXD_WATCHDOG_EN` and `WDT_CYCLES`=64, the UART never responds → `TIMEOUT` and `TXD_DONE` pulse together 64 cycles into WAIT, then IDLE. Without the macro, `BUSY` stays high after 1000 cycles.
